// File: rtl/data_bus_if_pkg.sv
// Shared definitions for the memory-stage data-bus master: FSM encodings
// and the common pipeline constants.
package data_bus_if_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE           = 2'b00,
    BUS_BUSY           = 2'b01,
    BUS_WAIT_FOR_STALL = 2'b10
  } bus_state_e;

  localparam int          RegBus   = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;

endpackage

// File: rtl/data_bus_if_if.sv
// Wishbone classic bus bundle between the data-bus master and its slave.
interface data_bus_if_if;

  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;

  modport master (
    input  wb_data_i, wb_ack_i,
    output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output wb_data_i, wb_ack_i,
    input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

endinterface

// File: rtl/data_bus_if.sv
// Memory-stage data-bus master: turns each mem-stage load/store into one
// Wishbone classic cycle and stalls the pipeline until it completes.
//
// Handshake: a request is taken in IDLE when cpu_ce_i=1 and flush=0;
// stallreq stays high until the cycle in which wb_ack_i (or a timeout or
// flush) ends the transfer, and that cycle presents the load data.
module data_bus_if
  import data_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [31:0]       cpu_data_i,
  output logic [RegBus-1:0] cpu_data_o,
  output logic              stallreq,
  output logic              bus_err_o,
  data_bus_if_if.master     wb,
  output bus_state_e        dbg_state
);

  bus_state_e  state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0] rd_buf;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;
  logic        we_q, stb_q, cyc_q;

  logic accept, ack_done, abort, timeout_hit, waiting;

  assign wb.wb_addr_o = addr_q;
  assign wb.wb_data_o = wdata_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_sel_o  = sel_q;
  assign wb.wb_stb_o  = stb_q;
  assign wb.wb_cyc_o  = cyc_q;
  assign dbg_state    = state;

  // Events that end or start a transfer; flush takes priority over ack.
  assign accept      = (state == BUS_IDLE) && cpu_ce_i && !flush;
  assign abort       = (state == BUS_BUSY) && flush;
  assign ack_done    = (state == BUS_BUSY) && wb.wb_ack_i && !flush;
  assign waiting     = (state == BUS_BUSY) && !wb.wb_ack_i && !flush;
  assign timeout_hit = waiting && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BUS_IDLE;
      cnt       <= '0;
      rd_buf    <= ZeroWord;
      addr_q    <= ZeroWord;
      wdata_q   <= ZeroWord;
      sel_q     <= 4'b0000;
      we_q      <= 1'b0;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_err_o <= timeout_hit;
      if (accept) begin
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_data_i;
        sel_q   <= cpu_sel_i;
        we_q    <= cpu_we_i;
        stb_q   <= 1'b1;
        cyc_q   <= 1'b1;
        cnt     <= '0;
      end else if (ack_done || abort || timeout_hit) begin
        addr_q  <= ZeroWord;
        wdata_q <= ZeroWord;
        sel_q   <= 4'b0000;
        we_q    <= 1'b0;
        stb_q   <= 1'b0;
        cyc_q   <= 1'b0;
      end else if (waiting) begin
        cnt <= cnt + 1'b1;
      end
      if (ack_done) begin
        rd_buf <= we_q ? ZeroWord : wb.wb_data_i;
      end else if (timeout_hit || abort) begin
        rd_buf <= ZeroWord;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    stallreq   = NoStop;
    cpu_data_o = ZeroWord;
    unique case (state)
      BUS_IDLE: begin
        stallreq = (cpu_ce_i && !flush) ? Stop : NoStop;
        if (accept) state_nxt = BUS_BUSY;
      end
      BUS_BUSY: begin
        if (flush) begin
          state_nxt = BUS_IDLE;
        end else if (wb.wb_ack_i) begin
          cpu_data_o = we_q ? ZeroWord : wb.wb_data_i;
          state_nxt  = (stall != 6'b000000) ? BUS_WAIT_FOR_STALL : BUS_IDLE;
        end else if (timeout_hit) begin
          state_nxt = BUS_WAIT_FOR_STALL;
        end else begin
          stallreq = Stop;
        end
      end
      BUS_WAIT_FOR_STALL: begin
        // Hold the result until the pipeline moves; new requests wait.
        cpu_data_o = rd_buf;
        if (stall == 6'b000000 || flush) state_nxt = BUS_IDLE;
      end
      default: state_nxt = BUS_IDLE;
    endcase
  end

endmodule
